// File: rtl/seg_capture.sv
// seg_capture: rebuilds the two 4-digit BCD values from the scanned seven-segment display bus
module seg_capture (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  dis_the4,
    input  logic [3:0]  dis_real4,
    input  logic [13:0] dis_all,
    input  logic        err_clr,
    output logic [15:0] bcd_the,
    output logic [15:0] bcd_real,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        sel_err,
    output logic        seq_err
);
    typedef enum logic {SYNC, LOCK} state_t;

    function automatic logic [3:0] dec(input logic [6:0] s);
        case (s)
            7'b1111110: dec = 4'h0;
            7'b0110000: dec = 4'h1;
            7'b1101101: dec = 4'h2;
            7'b1111001: dec = 4'h3;
            7'b0110011: dec = 4'h4;
            7'b1011011: dec = 4'h5;
            7'b1011111: dec = 4'h6;
            7'b1110000: dec = 4'h7;
            7'b1111111: dec = 4'h8;
            7'b1111011: dec = 4'h9;
            7'b0000000: dec = 4'hF;
            default:    dec = 4'hE;
        endcase
    endfunction

    state_t      state;
    logic [3:0]  the_q, real_q;
    logic [13:0] seg_q;
    logic [1:0]  exp_idx;
    logic [11:0] sh_the, sh_real;
    logic [3:0]  d_the, d_real;
    logic [1:0]  idx;
    logic        lock, good, in_order, bad_seg;

    assign d_the    = dec(seg_q[13:7]);
    assign d_real   = dec(seg_q[6:0]);
    assign idx      = {the_q[3] | the_q[2], the_q[3] | the_q[1]};
    assign good     = (the_q == real_q) && $onehot(the_q);
    assign lock     = (state == LOCK);
    assign in_order = lock && good && (idx == exp_idx);
    assign bad_seg  = (d_the == 4'hE) || (d_real == 4'hE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            the_q  <= '0;
            real_q <= '0;
            seg_q  <= '0;
        end else begin
            the_q  <= dis_the4;
            real_q <= dis_real4;
            seg_q  <= dis_all;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= SYNC;
            exp_idx     <= '0;
            sh_the      <= '0;
            sh_real     <= '0;
            bcd_the     <= '0;
            bcd_real    <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            sel_err     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= (seg_err & ~err_clr) | (lock & bad_seg);
            sel_err     <= (sel_err & ~err_clr) | (lock & ~good);
            seq_err     <= (seq_err & ~err_clr) | (lock & good & (idx != exp_idx));
            if (in_order && idx == 2'd3) begin
                bcd_the     <= {d_the, sh_the};
                bcd_real    <= {d_real, sh_real};
                frame_valid <= 1'b1;
                exp_idx     <= 2'd0;
            end else if (in_order || (good && idx == 2'd0)) begin
                // a clean ones digit (re)starts a frame from SYNC or after an out-of-order digit
                sh_the[{idx, 2'b00} +: 4]  <= d_the;
                sh_real[{idx, 2'b00} +: 4] <= d_real;
                exp_idx <= idx + 2'd1;
                state   <= LOCK;
            end else if (lock) begin
                state <= SYNC;
            end
        end
    end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed scan sequences with a frame scoreboard for seg_capture
module tb_seg_capture;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  dis_the4 = '0, dis_real4 = '0;
    logic [13:0] dis_all = '0;
    logic        err_clr = 1'b0;
    logic [15:0] bcd_the, bcd_real;
    logic        frame_valid, seg_err, sel_err, seq_err;

    typedef struct {
        int          due;
        logic [15:0] t;
        logic [15:0] r;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    seg_capture dut (
        .clk(clk), .rstn(rstn), .dis_the4(dis_the4), .dis_real4(dis_real4),
        .dis_all(dis_all), .err_clr(err_clr), .bcd_the(bcd_the), .bcd_real(bcd_real),
        .frame_valid(frame_valid), .seg_err(seg_err), .sel_err(sel_err), .seq_err(seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // E encodes an undecodable pattern, F a blank digit
    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b1111110;
            4'h1: enc = 7'b0110000;
            4'h2: enc = 7'b1101101;
            4'h3: enc = 7'b1111001;
            4'h4: enc = 7'b0110011;
            4'h5: enc = 7'b1011011;
            4'h6: enc = 7'b1011111;
            4'h7: enc = 7'b1110000;
            4'h8: enc = 7'b1111111;
            4'h9: enc = 7'b1111011;
            4'hE: enc = 7'b1000000;
            default: enc = 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] ts, input logic [3:0] rs, input logic [6:0] tg, input logic [6:0] rg);
        dis_the4  = ts;
        dis_real4 = rs;
        dis_all   = {tg, rg};
        @(posedge clk);
        #1;
    endtask

    task automatic d(input logic [15:0] t, input logic [15:0] r, input int i, input bit push);
        logic [3:0] sel;
        sel = 4'b0001 << i;
        if (push) q.push_back('{cyc + 2, t, r});
        step(sel, sel, enc(t[4*i +: 4]), enc(r[4*i +: 4]));
    endtask

    task automatic scan(input logic [15:0] t, input logic [15:0] r, input int from);
        for (int i = from; i < 4; i++) d(t, r, i, i == 3);
    endtask

    always @(negedge clk) begin
        if (rstn && frame_valid) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_frame observed=%h/%h expected=none", bcd_the, bcd_real);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("frame_the", bcd_the, e.t);
                chk("frame_real", bcd_real, e.r);
                chk("frame_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_the", bcd_the, 0);
        chk("rst_real", bcd_real, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_seg", seg_err, 0);
        chk("rst_sel", sel_err, 0);
        chk("rst_seq", seq_err, 0);
        rstn = 1'b1;
        scan(16'h1234, 16'h5678, 0);
        scan(16'h1234, 16'h5678, 0);
        d(16'hF321, 16'hF876, 0, 0);
        chk("steady_the", bcd_the, 16'h1234);
        chk("steady_real", bcd_real, 16'h5678);
        chk("steady_errs", {seg_err, sel_err, seq_err}, 0);
        scan(16'hF321, 16'hF876, 1);
        d(16'h4321, 16'h87E5, 0, 0);
        chk("blank_the", bcd_the, 16'hF321);
        chk("blank_real", bcd_real, 16'hF876);
        chk("blank_seg", seg_err, 0);
        scan(16'h4321, 16'h87E5, 1);
        chk("bad_seg_set", seg_err, 1);
        d(16'h1111, 16'h22E2, 0, 0);
        chk("bad_seg_real", bcd_real, 16'h87E5);
        chk("bad_seg_sticky", seg_err, 1);
        err_clr = 1'b1;
        d(16'h1111, 16'h22E2, 1, 0);
        err_clr = 1'b0;
        chk("seg_clr", seg_err, 0);
        err_clr = 1'b1;
        d(16'h1111, 16'h22E2, 2, 0);
        err_clr = 1'b0;
        chk("seg_clr_collide", seg_err, 1);
        d(16'h1111, 16'h22E2, 3, 1);
        d(16'h5555, 16'h6666, 0, 0);
        d(16'h5555, 16'h6666, 1, 0);
        d(16'h5555, 16'h6666, 3, 0);
        d(16'h7777, 16'h8888, 0, 0);
        chk("seq_set", seq_err, 1);
        chk("seq_hold_the", bcd_the, 16'h1111);
        chk("seq_hold_real", bcd_real, 16'h22E2);
        scan(16'h7777, 16'h8888, 1);
        err_clr = 1'b1;
        d(16'h1357, 16'h2468, 0, 0);
        err_clr = 1'b0;
        chk("clr_all", {seg_err, sel_err, seq_err}, 0);
        step(4'b0010, 4'b0100, enc(4'h1), enc(4'h2));
        step(4'b0000, 4'b0000, 7'd0, 7'd0);
        chk("sel_set", sel_err, 1);
        err_clr = 1'b1;
        step(4'b0000, 4'b0000, 7'd0, 7'd0);
        err_clr = 1'b0;
        step(4'b0000, 4'b0000, 7'd0, 7'd0);
        chk("sync_quiet", {seg_err, sel_err, seq_err}, 0);
        scan(16'h2222, 16'h3333, 0);
        d(16'h9876, 16'h5432, 0, 0);
        d(16'h9876, 16'h5432, 1, 0);
        rstn = 1'b0;
        #2;
        chk("async_the", bcd_the, 0);
        chk("async_real", bcd_real, 0);
        chk("async_flags", {frame_valid, seg_err, sel_err, seq_err}, 0);
        rstn = 1'b1;
        d(16'h9876, 16'h5432, 2, 0);
        d(16'h9876, 16'h5432, 3, 0);
        scan(16'h4080, 16'h1590, 0);
        d(16'h1111, 16'h1111, 0, 0);
        d(16'h1111, 16'h1111, 1, 0);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_capture.md
# seg_capture

Display-bus monitor that sits on the scanned seven-segment outputs of the theory/real display driver and reconstructs the two 4-digit BCD values being shown. It registers the one-hot digit selects and the 14-bit segment bus, decodes each segment pattern back to BCD, tracks the 4-phase scan sequence, and publishes a coherent frame once all four digits arrive in order. Used for on-chip self-check of the display path and as the readback source for the DDS test harness.

## Interface
- No parameters.
- clk  in  1  system clock, same domain as the display driver
- rstn  in  1  asynchronous active-low reset
- dis_the4  in  4  theory-channel digit select, one-hot (0001 = ones … 1000 = thousands)
- dis_real4  in  4  real-channel digit select, one-hot, same encoding
- dis_all  in  14  segments abcdefg, a = MSB; [13:7] theory, [6:0] real
- err_clr  in  1  synchronous clear of all sticky error flags
- bcd_the  out  16  {thou, hund, ten, one} theory value from last complete frame
- bcd_real  out  16  same for the real channel
- frame_valid  out  1  one-cycle pulse when bcd_the/bcd_real update
- seg_err  out  1  sticky: undecodable segment pattern seen while locked
- sel_err  out  1  sticky: dis_the4 ≠ dis_real4, or select not one-hot, while locked
- seq_err  out  1  sticky: digit index out of scan order while locked

## Operation
- Stage 1: dis_the4, dis_real4, dis_all registered every cycle (no reset dependence on data, reset to 0).
- Decode (per 7-bit field): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9, 0000000→4'hF (blank, legal), any other→4'hE plus seg_err set.
- Index: one-hot select → 0..3; selects must match and be one-hot, else "bad select".
- FSM states SYNC, LOCK; 2-bit exp_idx; 3×4-bit shadow per channel (digits 0-2).
- SYNC: ignore everything (no error flags) until registered select = 0001 on both channels → write shadow digit 0, exp_idx=1, go LOCK.
- LOCK, sample index = exp_idx, good select: idx 0-2 → write shadow[idx], exp_idx+1; idx 3 → load bcd outputs from shadow plus current decode, pulse frame_valid, exp_idx=0.
- LOCK, bad select → sel_err set, go SYNC. LOCK, good select but index ≠ exp_idx → seq_err set; if index = 0 restart immediately (shadow digit 0, exp_idx=1, stay LOCK), else go SYNC.
- seg_err only set in LOCK; decoded E/F values are still stored and published.
- bcd outputs hold their value between frames and through any error/resync.
- err_clr clears all three sticky flags; a new error in the same cycle wins (flag stays 1).

## Timing
- Reset: state SYNC, exp_idx 0, shadows 0, bcd_the = bcd_real = 16'h0000, frame_valid = seg_err = sel_err = seq_err = 0.
- Digit presented on inputs before edge N → in stage 1 after N → shadow/FSM updated at edge N+1.
- Latency: thousands digit on inputs before edge N → bcd outputs and frame_valid high after edge N+1 (2 cycles); frame_valid low next cycle.
- Driver advancing one digit per clock → frame_valid every 4 cycles in steady state.
- Error flags assert at the same edge N+1 as the offending sample is evaluated.
- Reset asserted mid-frame: all state cleared immediately; partial shadow discarded; first frame after release requires a fresh 0001.

## Test plan
- Reset, drive scan of theory 1234 / real 5678 → first frame_valid 5 cycles after first 0001 enters, bcd_the=16'h1234, bcd_real=16'h5678, pulse every 4 cycles thereafter, no errors.
- Thousands segments 0000000 on both channels → bcd_the[15:12]=bcd_real[15:12]=4'hF, seg_err stays 0.
- Real-channel tens pattern 7'b1000000 → bcd_real[7:4]=4'hE, seg_err=1 and sticky; err_clr pulse → 0; err_clr coinciding with another bad pattern → stays 1.
- Select sequence 0001,0010,1000 → seq_err=1, no frame_valid, outputs hold previous frame; next full 0001..1000 scan → normal frame.
- dis_the4=0010, dis_real4=0100 while locked → sel_err=1, FSM to SYNC; select 0000 during SYNC → no flag.
- rstn low after digits 0-1 of a frame → all outputs 0 asynchronously; after release, no frame_valid until a complete new scan.
